// File: rtl/curve_blend.sv
// curve_blend: per-frame adaptive blend between raw luma and a brightness
// curve. Each frame's mean luma sets the blend weight applied to the next
// frame. The weight comes from the mean, so bright frames lean toward raw
// luma and dark frames lean toward the curve.
//
// Pipeline handshake: there is no valid/ready pair. i_de qualifies a pixel
// in the cycle it is presented. o_de, o_vsync and o_y follow exactly two
// cycles later. The block never stalls and never applies backpressure.
module curve_blend #(
  parameter int         PIX_SHIFT  = 2,
  parameter logic [7:0] ALPHA_INIT = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic [7:0] i_y,
  input  logic [7:0] i_cy,
  output logic       o_vsync,
  output logic       o_de,
  output logic [7:0] o_y,
  output logic [7:0] o_alpha,
  output logic [7:0] o_mean
);

  // Frame statistics state
  logic        vs_d1;
  logic [31:0] sum;
  logic [23:0] cnt;

  // Stage 1 registers
  logic [16:0] p0;
  logic [15:0] p1;
  logic        de1;
  logic        vs1;

  // Combinational helpers
  logic        frame_start;
  logic [31:0] sum_shr;
  logic [7:0]  mean;
  logic [32:0] sum_add;
  logic [31:0] sum_inc;
  logic [23:0] cnt_inc;
  logic [8:0]  inv_alpha;
  logic [16:0] p0_n;
  logic [15:0] p1_n;
  logic [17:0] acc;

  assign frame_start = i_vsync & ~vs_d1;

  // Mean of the finished frame, clamped to 8 bits, plus saturating accumulate terms
  always_comb begin
    sum_shr   = sum >> PIX_SHIFT;
    mean      = (sum_shr > 32'd255) ? 8'hFF : sum_shr[7:0];
    sum_add   = {1'b0, sum} + {25'd0, i_y};
    sum_inc   = sum_add[32] ? 32'hFFFF_FFFF : sum_add[31:0];
    cnt_inc   = (cnt == 24'hFF_FFFF) ? cnt : cnt + 24'd1;
    inv_alpha = 9'd256 - {1'b0, o_alpha};
    p0_n      = {9'd0, i_y} * {8'd0, inv_alpha};
    p1_n      = {8'd0, i_cy} * {8'd0, o_alpha};
    acc       = {1'b0, p0} + {2'b0, p1} + 18'd128;
  end

  // Frame sync edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_d1 <= 1'b0;
    else        vs_d1 <= i_vsync;
  end

  // Luma sum and pixel count; restart at frame start, seeded by a coincident pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 32'd0;
      cnt <= 24'd0;
    end else if (frame_start) begin
      sum <= i_de ? {24'd0, i_y} : 32'd0;
      cnt <= i_de ? 24'd1 : 24'd0;
    end else if (i_de) begin
      sum <= sum_inc;
      cnt <= cnt_inc;
    end
  end

  // Publish mean and new weight at frame start; an empty frame keeps the old ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mean  <= 8'd0;
      o_alpha <= ALPHA_INIT;
    end else if (frame_start && (cnt != 24'd0)) begin
      o_mean  <= mean;
      o_alpha <= 8'd255 - mean;
    end
  end

  // Stage 1: weighted products using the weight in effect before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0  <= 17'd0;
      p1  <= 16'd0;
      de1 <= 1'b0;
      vs1 <= 1'b0;
    end else begin
      p0  <= p0_n;
      p1  <= p1_n;
      de1 <= i_de;
      vs1 <= i_vsync;
    end
  end

  // Stage 2: rounded blend; weights sum to 256 so the result fits in 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_y     <= 8'd0;
      o_de    <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      o_y     <= de1 ? 8'(acc >> 8) : 8'd0;
      o_de    <= de1;
      o_vsync <= vs1;
    end
  end

endmodule

// File: tb/tb_curve_blend.sv
// tb_curve_blend: directed and random stimulus for curve_blend with a
// reference model of the frame statistics and an expected-output queue.
module tb_curve_blend;

  localparam int         PS = 2;
  localparam logic [7:0] AI = 8'd128;

  logic       clk;
  logic       rst_n;
  logic       i_vsync;
  logic       i_de;
  logic [7:0] i_y;
  logic [7:0] i_cy;
  logic       o_vsync;
  logic       o_de;
  logic [7:0] o_y;
  logic [7:0] o_alpha;
  logic [7:0] o_mean;

  curve_blend #(.PIX_SHIFT(PS), .ALPHA_INIT(AI)) dut (
    .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .i_de(i_de),
    .i_y(i_y), .i_cy(i_cy), .o_vsync(o_vsync), .o_de(o_de),
    .o_y(o_y), .o_alpha(o_alpha), .o_mean(o_mean)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {vsync, de, y} expected at the output
  logic [9:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_alpha;
  logic [7:0] m_mean;
  longint     m_sum;
  longint     m_cnt;
  logic       m_vs;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply reset asynchronously, check reset values, release on a later negedge
  task automatic do_reset();
    @(negedge clk);
    i_vsync = 1'b0; i_de = 1'b0; i_y = 8'd0; i_cy = 8'd0;
    rst_n = 1'b0;
    #1;
    m_alpha = AI; m_mean = 8'd0; m_sum = 0; m_cnt = 0; m_vs = 1'b0;
    exp_q.delete();
    exp_q.push_back(10'd0);
    check("rst_pipe",  {o_vsync, o_de, o_y}, 10'd0);
    check("rst_alpha", {2'b0, o_alpha}, {2'b0, AI});
    check("rst_mean",  {2'b0, o_mean}, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: predict output and statistics, then compare
  task automatic step(input logic de, input logic vs, input logic [7:0] y, input logic [7:0] cy);
    int   ey;
    longint mn;
    logic [9:0] e;
    i_de = de; i_vsync = vs; i_y = y; i_cy = cy;
    ey = de ? ((int'(y) * (256 - int'(m_alpha)) + int'(cy) * int'(m_alpha) + 128) / 256) : 0;
    exp_q.push_back({vs, de, 8'(ey)});
    if (vs && !m_vs) begin
      if (m_cnt != 0) begin
        mn = m_sum >> PS;
        if (mn > 255) mn = 255;
        m_mean  = 8'(mn);
        m_alpha = 8'd255 - m_mean;
      end
      m_sum = de ? longint'(y) : 0;
      m_cnt = de ? 1 : 0;
    end else if (de) begin
      m_sum = m_sum + longint'(y);
      if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
      if (m_cnt < 24'hFF_FFFF) m_cnt = m_cnt + 1;
    end
    m_vs = vs;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pipe", {o_vsync, o_de, o_y}, e);
    end
    check("alpha", {2'b0, o_alpha}, {2'b0, m_alpha});
    check("mean",  {2'b0, o_mean},  {2'b0, m_mean});
  endtask

  logic [7:0] a_hold;

  initial begin
    rst_n = 1'b0; i_vsync = 1'b0; i_de = 1'b0; i_y = 8'd0; i_cy = 8'd0;

    // Post-reset blend with the initial weight
    do_reset();
    step(1'b1, 1'b0, 8'd100, 8'd150);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    check("blend125", {1'b0, o_de, o_y}, {1'b0, 1'b1, 8'd125});
    check("alpha128", {2'b0, o_alpha}, {2'b0, 8'd128});
    step(1'b0, 1'b0, 8'd0, 8'd0);

    // Frame statistics: empty first frame keeps the weight, then 4 pixels of 40
    do_reset();
    step(1'b0, 1'b1, 8'd0, 8'd0);
    check("empty_hold", {2'b0, o_alpha}, {2'b0, AI});
    step(1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd40, 8'd9);
    step(1'b0, 1'b1, 8'd0, 8'd0);
    check("mean40",   {2'b0, o_mean},  {2'b0, 8'd40});
    check("alpha215", {2'b0, o_alpha}, {2'b0, 8'd215});
    step(1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 8'd40, 8'd77);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    check("blend71", {2'b0, o_y}, {2'b0, 8'd71});

    // Bright frame drives the weight to zero, next frame passes luma unchanged
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd255, 8'd3);
    step(1'b0, 1'b1, 8'd0, 8'd0);
    check("alpha0", {2'b0, o_alpha}, 10'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 8'd0,   8'($urandom_range(0, 255)));
    step(1'b1, 1'b0, 8'd17,  8'($urandom_range(0, 255)));
    check("ident0", {2'b0, o_y}, 10'd0);
    step(1'b1, 1'b0, 8'd255, 8'($urandom_range(0, 255)));
    check("ident17", {2'b0, o_y}, 10'd17);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    check("ident255", {2'b0, o_y}, 10'd255);

    // Close that frame (mean 68), then a saturating frame of 8 x 200
    step(1'b0, 1'b1, 8'd0, 8'd0);
    check("alpha187", {2'b0, o_alpha}, 10'd187);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'd200, 8'd50);
    step(1'b0, 1'b1, 8'd0, 8'd0);
    check("sat_mean",  {2'b0, o_mean},  10'd255);
    check("sat_alpha", {2'b0, o_alpha}, 10'd0);

    // Two edges with no pixels between them leave the weight alone
    a_hold = o_alpha;
    step(1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 8'd0, 8'd0);
    check("empty_frame", {2'b0, o_alpha}, {2'b0, a_hold});
    step(1'b0, 1'b0, 8'd0, 8'd0);

    // Mid-frame reset discards the partial sum
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd10, 8'd20);
    do_reset();
    step(1'b0, 1'b1, 8'd0, 8'd0);
    check("mid_rst_alpha", {2'b0, o_alpha}, {2'b0, AI});
    check("mid_rst_mean",  {2'b0, o_mean},  10'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0);

    // Random de/vsync pattern, including pixels during vsync
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    step(1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
